// File: rtl/buf_id_mgmt.sv
// Buffer-ID manager: circular free list of IDs with an allocated bitmap and double-free detection.
// Optional feature macro BUF_ID_REFCNT_EN adds a per-ID 4-bit reader count that gates the return of an ID.
module buf_id_mgmt #(
  parameter  int ID_W    = 4,
  parameter  int OFF_W   = 7,
  localparam int NUM_BUF = 1 << ID_W,
  localparam int ADDR_W  = ID_W + OFF_W,
  localparam int CNT_W   = ID_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_req,
  output logic              alloc_gnt,
  output logic [ID_W-1:0]   alloc_id,
  output logic [ADDR_W-1:0] alloc_waddr,
  input  logic [3:0]        alloc_ref,
  input  logic              free_req,
  input  logic [ID_W-1:0]   free_id,
  output logic [ADDR_W-1:0] free_raddr,
  output logic              free_raddr_wr,
  output logic [CNT_W-1:0]  free_cnt,
  output logic              init_done,
  output logic              err_free
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    fifo_mem [NUM_BUF];
  logic [ID_W-1:0]    rd_ptr, wr_ptr, init_idx;
  logic [NUM_BUF-1:0] alloc_map;
  logic [ID_W-1:0]    head_id, push_id;
  logic               pop, push, push_init, push_free;
  logic               free_legal, free_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (&init_idx) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
    endcase
  end

  // Grant decisions see only the registered count, so a same-cycle return never feeds an empty list.
  assign head_id      = fifo_mem[rd_ptr];
  assign pop          = (state == ST_RUN) && alloc_req && (free_cnt != '0) && !alloc_gnt;
  assign free_legal   = (state == ST_RUN) && free_req && alloc_map[free_id];
  assign free_illegal = (state == ST_RUN) && free_req && !alloc_map[free_id];
  assign push_init    = (state == ST_INIT);
  assign push         = push_init || push_free;
  assign push_id      = push_init ? init_idx : free_id;

`ifdef BUF_ID_REFCNT_EN
  logic [3:0] ref_cnt [NUM_BUF];

  // The last reader's release is the one that returns the ID; a zero load means a single reader.
  assign push_free = free_legal && (ref_cnt[free_id] <= 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BUF; i++) ref_cnt[i] <= '0;
    end else begin
      if (pop)        ref_cnt[head_id] <= (alloc_ref == 4'd0) ? 4'd1 : alloc_ref;
      if (free_legal) ref_cnt[free_id] <= ref_cnt[free_id] - 4'd1;
    end
  end
`else
  logic unused_ref;
  assign unused_ref = ^alloc_ref;
  assign push_free  = free_legal;
`endif

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      init_idx  <= '0;
      free_cnt  <= '0;
      init_done <= 1'b0;
      alloc_map <= '0;
    end else begin
      if (push_init) init_idx <= init_idx + ID_W'(1);
      if (pop)       rd_ptr   <= rd_ptr + ID_W'(1);
      if (push)      wr_ptr   <= wr_ptr + ID_W'(1);
      case ({push, pop})
        2'b10:   free_cnt <= free_cnt + CNT_W'(1);
        2'b01:   free_cnt <= free_cnt - CNT_W'(1);
        default: free_cnt <= free_cnt;
      endcase
      if (state_nxt == ST_RUN) init_done <= 1'b1;
      if (pop)       alloc_map[head_id] <= 1'b1;
      if (push_free) alloc_map[free_id] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_gnt     <= 1'b0;
      alloc_id      <= '0;
      alloc_waddr   <= '0;
      free_raddr_wr <= 1'b0;
      free_raddr    <= '0;
      err_free      <= 1'b0;
    end else begin
      alloc_gnt     <= pop;
      free_raddr_wr <= free_legal;
      err_free      <= free_illegal;
      if (pop) begin
        alloc_id    <= head_id;
        alloc_waddr <= {head_id, {OFF_W{1'b0}}};
      end
      if (free_legal) free_raddr <= {free_id, {OFF_W{1'b0}}};
    end
  end

endmodule

// File: tb/tb_buf_id_mgmt.sv
// Self-checking bench for buf_id_mgmt: queue-based free-list model compared every cycle plus directed literal checks.
module tb_buf_id_mgmt;
  localparam int ID_W    = 4;
  localparam int OFF_W   = 7;
  localparam int NUM_BUF = 16;
  localparam int ADDR_W  = ID_W + OFF_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              alloc_req = 1'b0;
  logic              free_req = 1'b0;
  logic [3:0]        alloc_ref = 4'd0;
  logic [ID_W-1:0]   free_id = '0;
  logic              alloc_gnt, free_raddr_wr, init_done, err_free;
  logic [ID_W-1:0]   alloc_id;
  logic [ADDR_W-1:0] alloc_waddr, free_raddr;
  logic [ID_W:0]     free_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  buf_id_mgmt #(.ID_W(ID_W), .OFF_W(OFF_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_id(alloc_id),
    .alloc_waddr(alloc_waddr), .alloc_ref(alloc_ref),
    .free_req(free_req), .free_id(free_id), .free_raddr(free_raddr),
    .free_raddr_wr(free_raddr_wr), .free_cnt(free_cnt),
    .init_done(init_done), .err_free(err_free)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: free list as a queue, allocation flags per ID, expected outputs per cycle.
  int mq[$];
  bit m_alloc[NUM_BUF];
`ifdef BUF_ID_REFCNT_EN
  int m_rc[NUM_BUF];
`endif
  int m_n = 0;
  bit e_gnt = 0, e_rwr = 0, e_err = 0, e_done = 0;
  int e_id = 0, e_rid = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_n = 0; e_gnt = 0; e_rwr = 0; e_err = 0; e_done = 0;
      for (int i = 0; i < NUM_BUF; i++) begin
        m_alloc[i] = 0;
`ifdef BUF_ID_REFCNT_EN
        m_rc[i] = 0;
`endif
      end
    end else if (!e_done) begin
      mq.push_back(m_n);
      m_n++;
      e_done = (m_n == NUM_BUF);
    end else begin
      bit g, legal, give_back;
      int gid;
      legal = free_req && m_alloc[free_id];
      g     = alloc_req && (mq.size() > 0) && !e_gnt;
      e_err = free_req && !legal;
      e_rwr = legal;
      if (legal) e_rid = int'(free_id);
      if (g) begin
        gid = mq.pop_front();
        m_alloc[gid] = 1;
        e_id = gid;
`ifdef BUF_ID_REFCNT_EN
        m_rc[gid] = (alloc_ref == 4'd0) ? 1 : int'(alloc_ref);
`endif
      end
      give_back = legal;
`ifdef BUF_ID_REFCNT_EN
      if (legal) begin
        m_rc[free_id] = m_rc[free_id] - 1;
        give_back = (m_rc[free_id] == 0);
      end
`endif
      if (give_back) begin
        mq.push_back(int'(free_id));
        m_alloc[free_id] = 0;
      end
      e_gnt = g;
    end
  end

  always @(negedge clk) begin
    chk("m_gnt",  32'(alloc_gnt),     32'(e_gnt));
    chk("m_done", 32'(init_done),     32'(e_done));
    chk("m_cnt",  32'(free_cnt),      mq.size());
    chk("m_rwr",  32'(free_raddr_wr), 32'(e_rwr));
    chk("m_err",  32'(err_free),      32'(e_err));
    if (e_gnt) begin
      chk("m_id",    32'(alloc_id),    e_id);
      chk("m_waddr", 32'(alloc_waddr), e_id << OFF_W);
    end
    if (e_rwr) chk("m_raddr", 32'(free_raddr), e_rid << OFF_W);
  end

  task automatic wait_init(output int k);
    k = 0;
    while (!init_done && k < 40) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic free_one(input int id);
    free_id  = ID_W'(id);
    free_req = 1'b1;
    @(negedge clk);
    free_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, ng, last;
    repeat (3) @(negedge clk);
    chk("rst_cnt",  32'(free_cnt),  0);
    chk("rst_done", 32'(init_done), 0);
    chk("rst_gnt",  32'(alloc_gnt), 0);

    // Initialisation and first grants
    rst_n = 1'b1;
    wait_init(k);
    chk("init_cycles", k, 16);
    chk("init_cnt", 32'(free_cnt), 16);
    alloc_req = 1'b1;
    ng = 0; last = -2;
    for (int c = 1; c <= 60 && ng < 16; c++) begin
      @(negedge clk);
      if (alloc_gnt) begin
        if (ng < 3) begin
          chk("first_id", 32'(alloc_id), ng);
          chk("first_waddr", 32'(alloc_waddr), ng * 128);
          if (ng > 0) chk("gnt_spacing", c - last, 2);
        end
        last = c;
        ng++;
      end
    end
    chk("grants_all", ng, 16);
    ng = 0;
    repeat (6) begin
      @(negedge clk);
      if (alloc_gnt) ng++;
    end
    chk("empty_nogrant", ng, 0);

    // Return ID 5 while the list is empty and alloc_req is held
    free_one(5);
    chk("f5_wr", 32'(free_raddr_wr), 1);
    chk("f5_raddr", 32'(free_raddr), 'h280);
    k = 0; ng = -1;
    while (k < 3 && ng < 0) begin
      @(negedge clk);
      k++;
      if (alloc_gnt) ng = int'(alloc_id);
    end
    chk("regrant5", ng, 5);
    alloc_req = 1'b0;

    // Double free of a free ID
    for (int i = 8; i < 16; i++) free_one(i);
    chk("cnt8", 32'(free_cnt), 8);
    free_one(9);
    chk("dbl_err", 32'(err_free), 1);
    chk("dbl_nowr", 32'(free_raddr_wr), 0);
    chk("dbl_cnt", 32'(free_cnt), 8);

    // Simultaneous grant and free at free_cnt=8
    alloc_req = 1'b1;
    free_one(2);
    alloc_req = 1'b0;
    chk("sim_gnt", 32'(alloc_gnt), 1);
    chk("sim_id", 32'(alloc_id), 8);
    chk("sim_wr", 32'(free_raddr_wr), 1);
    chk("sim_raddr", 32'(free_raddr), 'h100);
    chk("sim_cnt", 32'(free_cnt), 8);
    free_one(2);
    chk("sim_dbl2", 32'(err_free), 1);
    free_one(8);
    chk("sim_f8", 32'(free_raddr_wr), 1);
    @(negedge clk);
    chk("cnt9", 32'(free_cnt), 9);

    // Reset mid-allocation, then mid-initialisation
    alloc_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mr_gnt",   32'(alloc_gnt),     0);
    chk("mr_id",    32'(alloc_id),      0);
    chk("mr_waddr", 32'(alloc_waddr),   0);
    chk("mr_rwr",   32'(free_raddr_wr), 0);
    chk("mr_raddr", 32'(free_raddr),    0);
    chk("mr_cnt",   32'(free_cnt),      0);
    chk("mr_done",  32'(init_done),     0);
    chk("mr_err",   32'(err_free),      0);
    alloc_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("midinit_cnt", 32'(free_cnt), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("midinit_rst", 32'(free_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init(k);
    chk("reinit_cycles", k, 16);
    chk("reinit_cnt", 32'(free_cnt), 16);
    alloc_ref = 4'd3;
    alloc_req = 1'b1;
    k = 0; ng = -1;
    while (k < 4 && ng < 0) begin
      @(negedge clk);
      k++;
      if (alloc_gnt) ng = int'(alloc_id);
    end
    chk("reinit_first", ng, 0);

`ifdef BUF_ID_REFCNT_EN
    // Three readers on ID 3: only the third release returns it
    ng = 1; k = 0;
    while (ng < 4 && k < 20) begin
      @(negedge clk);
      k++;
      if (alloc_gnt) ng++;
    end
    alloc_req = 1'b0;
    chk("rc_grants", ng, 4);
    chk("rc_id3", 32'(alloc_id), 3);
    free_one(3);
    chk("rc_wr1", 32'(free_raddr_wr), 1);
    chk("rc_cnt1", 32'(free_cnt), 12);
    free_one(3);
    chk("rc_wr2", 32'(free_raddr_wr), 1);
    chk("rc_cnt2", 32'(free_cnt), 12);
    free_one(3);
    chk("rc_wr3", 32'(free_raddr_wr), 1);
    chk("rc_cnt3", 32'(free_cnt), 13);
`else
    alloc_req = 1'b0;
`endif
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/buf_id_mgmt.md
BUF_ID_MGMT -- requirements
Module: buf_id_mgmt

Interface
REQ-001 The block SHALL have parameter ID_W, default 4, giving buffer-ID width and NUM_BUF = 2^ID_W buffers.
REQ-002 The block SHALL have parameter OFF_W, default 7, giving word-offset width per buffer, with ADDR_W = ID_W+OFF_W.
REQ-003 The block SHALL have these ports:
 clk  in  1  sole clock, rising edge
 rst_n  in  1  asynchronous active-low reset
 alloc_req  in  1  request one free buffer, level
 alloc_gnt  out  1  one-cycle grant pulse
 alloc_id  out  ID_W  granted ID, valid with alloc_gnt
 alloc_waddr  out  ADDR_W  {alloc_id, OFF_W zeros}, valid with alloc_gnt
 alloc_ref  in  4  reader count for the requested buffer, sampled with alloc_req
 free_req  in  1  one-cycle release strobe
 free_id  in  ID_W  ID being released
 free_raddr  out  ADDR_W  {free_id, zeros} base read address
 free_raddr_wr  out  1  one-cycle pulse qualifying free_raddr
 free_cnt  out  ID_W+1  IDs currently in free list
 init_done  out  1  free list initialised
 err_free  out  1  one-cycle pulse: illegal release ignored

Function
REQ-004 The free list SHALL be an internal NUM_BUF-entry circular FIFO of IDs with read/write pointers of ID_W bits wrapping modulo NUM_BUF and a separate ID_W+1-bit count.
REQ-005 After reset, an INIT state SHALL push IDs 0..NUM_BUF-1 one per cycle, then enter RUN and assert init_done, NUM_BUF cycles after reset release.
REQ-006 alloc_req and free_req SHALL be ignored while init_done is 0.
REQ-007 In RUN, when alloc_req=1, free_cnt>0 and no grant occurred the previous cycle, the block SHALL pop the head ID and assert alloc_gnt with alloc_id/alloc_waddr on the next cycle.
REQ-008 Grants SHALL be at most one every two cycles; alloc_req held high SHALL yield grants on alternate cycles while IDs remain.
REQ-009 With free_cnt=0, alloc_req SHALL produce no grant and no state change until an ID is returned.
REQ-010 A per-ID allocated bitmap SHALL be set on grant and cleared when the ID re-enters the free list.
REQ-011 On free_req for an allocated ID, the block SHALL pulse free_raddr_wr with free_raddr the following cycle.
REQ-012 On free_req for an unallocated ID (double free), the block SHALL pulse err_free the following cycle and change no state.
REQ-013 A returned ID SHALL be pushed at the free-list tail and be grantable from the cycle after the push.
REQ-014 A pop and push in the same cycle SHALL both complete with free_cnt unchanged; grant decisions SHALL use the registered free_cnt, so a simultaneous free never satisfies an allocation when free_cnt=0.
REQ-015 free_cnt SHALL never exceed NUM_BUF or underflow; a push at free_cnt=NUM_BUF is impossible by REQ-010/012.
REQ-016 free_cnt SHALL be a registered output reflecting all pushes/pops of the previous cycle.

Reset
REQ-017 On rst_n low, all outputs SHALL be 0 (free_cnt=0, init_done=0), pointers, bitmap and reference counts SHALL clear, and the state SHALL be INIT, including when asserted mid-allocation or mid-initialisation.
REQ-018 Initialisation SHALL restart from ID 0 on every reset release.

Configuration
REQ-019 With macro BUF_ID_REFCNT_EN defined, each ID SHALL carry a 4-bit reference counter loaded from alloc_ref on grant (0 treated as 1); each legal free_req SHALL pulse free_raddr_wr, decrement the counter, and push the ID only when it reaches 0.
REQ-020 Without BUF_ID_REFCNT_EN, alloc_ref SHALL be ignored, no counters SHALL be synthesised, and every legal free_req SHALL push its ID immediately.

Verification
REQ-021 Reset release, ID_W=4 -> init_done rises after 16 cycles, free_cnt=16, first grants with alloc_req held give IDs 0,1,2 on alternate cycles, alloc_waddr 0x000,0x080,0x100.
REQ-022 Grant all 16, hold alloc_req -> no grant; free_req id=5 -> free_raddr_wr with free_raddr 0x280, then grant of ID 5 within 2 cycles.
REQ-023 free_req id=9 while ID 9 is free -> err_free pulse, free_cnt unchanged, no free_raddr_wr.
REQ-024 With free_cnt=8, simultaneous grant and free in one cycle -> free_cnt stays 8, both IDs tracked correctly.
REQ-025 BUF_ID_REFCNT_EN defined, grant ID 3 with alloc_ref=3 -> three free_req id=3 give three free_raddr_wr pulses, free_cnt increments only after the third.
REQ-026 rst_n asserted mid-allocation -> outputs 0 immediately, full re-initialisation to free_cnt=16 after release.
